// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector address generator slice.
package vec_pkg;

    localparam int VREG_IDX_W = 5;
    localparam int N_VEC      = 31;
    localparam int VLMAX_DEF  = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } agu_state_t;

    // Flat element address; callers truncate to their address width.
    function automatic logic [63:0] vec_elem_addr(input logic [VREG_IDX_W-1:0] vreg,
                                                  input logic [63:0]            elem,
                                                  input int                     vlmax = VLMAX_DEF);
        return 64'(vreg) * 64'(vlmax + 1) + elem;
    endfunction

endpackage

// File: rtl/vec_agu_if.sv
// Issue-side handshake plus register-file address bus of vec_agu.
// VEC_AGU_SCALAR_BCAST_EN adds the bcast_a request field.
interface vec_agu_if
    import vec_pkg::*;
#(
    parameter int ADDR_WIDTH = 31
);
    logic                  req_valid;
    logic                  req_ready;
    logic [VREG_IDX_W-1:0] vs1;
    logic [VREG_IDX_W-1:0] vs2;
    logic [VREG_IDX_W-1:0] vd;
    logic [ADDR_WIDTH:0]   vl;
`ifdef VEC_AGU_SCALAR_BCAST_EN
    logic                  bcast_a;
`endif
    logic [ADDR_WIDTH:0]   Aa;
    logic [ADDR_WIDTH:0]   Ab;
    logic [ADDR_WIDTH:0]   Ac;
    logic                  req_validAddrA;
    logic                  req_validAddrB;
    logic                  req_validAddrC;
    logic                  resp_valid;
    logic                  resp_ready;

    modport master (
        output req_valid, vs1, vs2, vd, vl,
`ifdef VEC_AGU_SCALAR_BCAST_EN
        output bcast_a,
`endif
        output resp_ready,
        input  req_ready, Aa, Ab, Ac, req_validAddrA, req_validAddrB, req_validAddrC, resp_valid
    );

    modport slave (
        input  req_valid, vs1, vs2, vd, vl,
`ifdef VEC_AGU_SCALAR_BCAST_EN
        input  bcast_a,
`endif
        input  resp_ready,
        output req_ready, Aa, Ab, Ac, req_validAddrA, req_validAddrB, req_validAddrC, resp_valid
    );

endinterface

// File: rtl/vec_agu_wb_pipe.sv
// Writeback delay line: WB_LAT-deep valid+address shift register.
module vec_agu_wb_pipe #(
    parameter int WB_LAT = 2,
    parameter int AW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    output logic          out_vld,
    output logic [AW-1:0] out_addr,
    output logic          any_valid
);

    logic [WB_LAT-1:0]         vld_pipe;
    logic [WB_LAT-1:0][AW-1:0] addr_pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[0]  <= in_vld;
            addr_pipe[0] <= in_addr;
            for (int s = 1; s < WB_LAT; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                addr_pipe[s] <= addr_pipe[s-1];
            end
        end
    end

    assign out_vld  = vld_pipe[WB_LAT-1];
    assign out_addr = addr_pipe[WB_LAT-1];

    // Writes still owed after the coming edge; the output stage leaves on that edge.
    always_comb begin
        any_valid = in_vld;
        for (int s = 0; s < WB_LAT - 1; s++) any_valid = any_valid | vld_pipe[s];
    end

endmodule

// File: rtl/vec_agu.sv
// Vector address generator/sequencer feeding the register file A/B read and C write ports.
// VEC_AGU_SCALAR_BCAST_EN: hold Aa at element 0 of vs1 when bcast_a is set on accept.
module vec_agu
    import vec_pkg::*;
#(
    parameter int VLMAX      = 31,
    parameter int ADDR_WIDTH = 31,
    parameter int WB_LAT     = 2
) (
    input  logic      clk,
    input  logic      rst,
    vec_agu_if.slave  bus
);

    typedef logic [ADDR_WIDTH:0] addr_t;
    localparam addr_t VL_FULL = addr_t'(VLMAX + 1);

    agu_state_t state;
    addr_t      base_a, base_b, base_d;
    addr_t      vl_eff, cnt;
    addr_t      aa_q, ab_q, d_q;
    logic       v_ab;
    logic       wb_any;
`ifdef VEC_AGU_SCALAR_BCAST_EN
    logic       bcast_q;
`endif

    addr_t acc_a, acc_b, acc_d, acc_vl;
    assign acc_a  = addr_t'(vec_elem_addr(bus.vs1, 64'd0, VLMAX));
    assign acc_b  = addr_t'(vec_elem_addr(bus.vs2, 64'd0, VLMAX));
    assign acc_d  = addr_t'(vec_elem_addr(bus.vd,  64'd0, VLMAX));
    assign acc_vl = (bus.vl > VL_FULL) ? VL_FULL : bus.vl;

    // Element 0 is registered on the accept edge so it is visible in the first cycle after accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            base_a <= '0;
            base_b <= '0;
            base_d <= '0;
            vl_eff <= '0;
            cnt    <= '0;
            aa_q   <= '0;
            ab_q   <= '0;
            d_q    <= '0;
            v_ab   <= 1'b0;
`ifdef VEC_AGU_SCALAR_BCAST_EN
            bcast_q <= 1'b0;
`endif
        end else begin
            v_ab <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        base_a <= acc_a;
                        base_b <= acc_b;
                        base_d <= acc_d;
                        vl_eff <= acc_vl;
`ifdef VEC_AGU_SCALAR_BCAST_EN
                        bcast_q <= bus.bcast_a;
`endif
                        if (acc_vl == '0) begin
                            cnt   <= '0;
                            state <= RESP;
                        end else begin
                            aa_q  <= acc_a;
                            ab_q  <= acc_b;
                            d_q   <= acc_d;
                            v_ab  <= 1'b1;
                            cnt   <= addr_t'(1);
                            state <= (acc_vl == addr_t'(1)) ? DRAIN : ISSUE;
                        end
                    end
                end
                ISSUE: begin
`ifdef VEC_AGU_SCALAR_BCAST_EN
                    aa_q <= bcast_q ? base_a : base_a + cnt;
`else
                    aa_q <= base_a + cnt;
`endif
                    ab_q <= base_b + cnt;
                    d_q  <= base_d + cnt;
                    v_ab <= 1'b1;
                    cnt  <= cnt + addr_t'(1);
                    if (cnt == vl_eff - addr_t'(1)) state <= DRAIN;
                end
                DRAIN: begin
                    if (!wb_any) state <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    vec_agu_wb_pipe #(
        .WB_LAT (WB_LAT),
        .AW     (ADDR_WIDTH + 1)
    ) u_wb_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (v_ab),
        .in_addr   (d_q),
        .out_vld   (bus.req_validAddrC),
        .out_addr  (bus.Ac),
        .any_valid (wb_any)
    );

    assign bus.req_ready      = (state == IDLE);
    assign bus.resp_valid     = (state == RESP);
    assign bus.Aa             = aa_q;
    assign bus.Ab             = ab_q;
    assign bus.req_validAddrA = v_ab;
    assign bus.req_validAddrB = v_ab;

endmodule

// File: tb/tb_vec_agu.sv
// Directed self-checking bench for vec_agu (WB_LAT=2, VLMAX=31).
module tb_vec_agu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_agu_if #(.ADDR_WIDTH(31)) bus();

    vec_agu #(
        .VLMAX      (31),
        .ADDR_WIDTH (31),
        .WB_LAT     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Returns just after the accept edge; the next negedge samples cycle 1.
    task automatic issue(input int a, input int b, input int d, input int len);
        @(negedge clk);
        bus.vs1       = 5'(a);
        bus.vs2       = 5'(b);
        bus.vd        = 5'(d);
        bus.vl        = 32'(len);
        bus.req_valid = 1'b1;
        chk("req_ready_pre", 32'(bus.req_ready), 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic finish_resp();
        int n = 0;
        bus.resp_ready = 1'b1;
        while (!bus.resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", 32'(bus.resp_valid), 1);
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(bus.req_ready), 1);
        chk("idle_resp", 32'(bus.resp_valid), 0);
    endtask

    task automatic run_basic(input string tag);
        issue(1, 2, 3, 4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk({tag, "_va"}, 32'(bus.req_validAddrA), 32'(k <= 4));
            chk({tag, "_vb"}, 32'(bus.req_validAddrB), 32'(k <= 4));
            if (k <= 4) begin
                chk({tag, "_aa"}, bus.Aa, 32'(31 + k));
                chk({tag, "_ab"}, bus.Ab, 32'(63 + k));
            end else if (k <= 6) begin
                chk({tag, "_aa_hold"}, bus.Aa, 35);
            end
            chk({tag, "_vc"}, 32'(bus.req_validAddrC), 32'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk({tag, "_ac"}, bus.Ac, 32'(93 + k));
            chk({tag, "_resp"}, 32'(bus.resp_valid), 32'(k >= 7));
            chk({tag, "_rdy"}, 32'(bus.req_ready), 0);
        end
        finish_resp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int na, nc, last_a, resp_k, acc2, lastc1, firsta2, nc2;
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.vs1        = '0;
        bus.vs2        = '0;
        bus.vd         = '0;
        bus.vl         = '0;
`ifdef VEC_AGU_SCALAR_BCAST_EN
        bus.bcast_a    = 1'b0;
`endif
        #2;
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_resp", 32'(bus.resp_valid), 0);
        chk("rst_va", 32'(bus.req_validAddrA), 0);
        chk("rst_vc", 32'(bus.req_validAddrC), 0);
        chk("rst_aa", bus.Aa, 0);
        chk("rst_ac", bus.Ac, 0);
        @(negedge clk);
        rst = 1'b1;

        run_basic("t1");

        // Zero length: straight to response, held while resp_ready is low.
        issue(0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("t2_resp", 32'(bus.resp_valid), 1);
            chk("t2_rdy", 32'(bus.req_ready), 0);
            chk("t2_va", 32'(bus.req_validAddrA), 0);
            chk("t2_vc", 32'(bus.req_validAddrC), 0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("t2_resp_drop", 32'(bus.resp_valid), 0);
        chk("t2_rdy_back", 32'(bus.req_ready), 1);
        bus.resp_ready = 1'b0;

        // Over-length request clamps to 32 elements.
        issue(4, 5, 6, 100);
        na = 0; nc = 0; last_a = 0; resp_k = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.req_validAddrA) begin
                na++;
                last_a = int'(bus.Aa);
            end
            if (bus.req_validAddrC) nc++;
            if (bus.resp_valid && resp_k == 0) resp_k = k;
        end
        chk("t3_na", na, 32);
        chk("t3_nc", nc, 32);
        chk("t3_last_aa", last_a, 159);
        chk("t3_resp_cyc", resp_k, 35);
        finish_resp();

        // Reset in the middle of an instruction.
        issue(1, 2, 3, 8);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t4_va", 32'(bus.req_validAddrA), 0);
        chk("t4_vb", 32'(bus.req_validAddrB), 0);
        chk("t4_vc", 32'(bus.req_validAddrC), 0);
        chk("t4_rdy", 32'(bus.req_ready), 1);
        chk("t4_resp", 32'(bus.resp_valid), 0);
        chk("t4_aa", bus.Aa, 0);
        chk("t4_ac", bus.Ac, 0);
        @(negedge clk);
        rst = 1'b1;
        run_basic("t4r");

        // Back-to-back with resp_ready tied high.
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.vs1 = 5'd1; bus.vs2 = 5'd2; bus.vd = 5'd3; bus.vl = 32'd4;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.vs1 = 5'd7; bus.vs2 = 5'd8; bus.vd = 5'd9; bus.vl = 32'd2;
        acc2 = 0; lastc1 = 0; firsta2 = 0; nc2 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (acc2 != 0) bus.req_valid = 1'b0;
            if (bus.req_ready && acc2 == 0) acc2 = k;
            if (bus.req_validAddrC && bus.Ac >= 96 && bus.Ac <= 99) lastc1 = k;
            if (bus.req_validAddrC && bus.Ac >= 288 && bus.Ac <= 289) nc2++;
            if (bus.req_validAddrA && bus.Aa >= 224 && bus.Aa <= 225 && firsta2 == 0) firsta2 = k;
        end
        chk("t5_acc2", acc2, 8);
        chk("t5_last_c1", lastc1, 6);
        chk("t5_first_a2", firsta2, 9);
        chk("t5_nc2", nc2, 2);
        chk("t5_idle", 32'(bus.req_ready), 1);
        bus.resp_ready = 1'b0;

`ifdef VEC_AGU_SCALAR_BCAST_EN
        bus.bcast_a = 1'b1;
        issue(5, 1, 2, 3);
        bus.bcast_a = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t6_va", 32'(bus.req_validAddrA), 1);
            chk("t6_aa", bus.Aa, 160);
            chk("t6_ab", bus.Ab, 32'(31 + k));
        end
        finish_resp();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
